// File: rtl/seq_chunk_adder_if.sv
// seq_chunk_adder_if: operand/result handshake bundle; SEQ_CHUNK_ADDER_SUB_EN adds the sub line
interface seq_chunk_adder_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic             carryin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carryout;
  logic             overflow;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  logic             sub;
`endif
  modport master (
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, carryin, x, y, out_ready,
    input  in_ready, out_valid, sum, carryout, overflow
  );
  modport slave (
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, carryin, x, y, out_ready,
    output in_ready, out_valid, sum, carryout, overflow
  );
endinterface

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: WIDTH-bit adder working CHUNK bits per clock with valid/ready in and out; SEQ_CHUNK_ADDER_SUB_EN adds subtract mode
module seq_chunk_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  seq_chunk_adder_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);
  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] x_q, y_q, r_q, sum_q;
  logic             c_q, co_q, ov_q, in_ready_q, out_valid_q;
  logic [CW-1:0]    cnt_q;
  logic [CHUNK:0]   add_d;
  logic [WIDTH-1:0] r_d, y_in_d;
  logic             c_in_d, msb_c_d;
  // one chunk slice, result shifted in from the MSB end, and operand conditioning at capture
  always_comb begin
    add_d = {1'b0, x_q[CHUNK-1:0]} + {1'b0, y_q[CHUNK-1:0]} + (CHUNK+1)'(c_q);
    r_d = WIDTH'({add_d[CHUNK-1:0], r_q} >> CHUNK);
    msb_c_d = add_d[CHUNK-1] ^ x_q[CHUNK-1] ^ y_q[CHUNK-1];
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    y_in_d = bus.sub ? ~bus.y : bus.y;
    c_in_d = bus.sub | bus.carryin;
`else
    y_in_d = bus.y;
    c_in_d = bus.carryin;
`endif
  end
  // control FSM with datapath registers; result is loaded on the last ADD edge so latency is NCHUNK
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q <= '0;
      y_q <= '0;
      r_q <= '0;
      sum_q <= '0;
      c_q <= 1'b0;
      co_q <= 1'b0;
      ov_q <= 1'b0;
      cnt_q <= '0;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.in_valid) begin
          x_q <= bus.x;
          y_q <= y_in_d;
          c_q <= c_in_d;
          cnt_q <= '0;
          in_ready_q <= 1'b0;
          state_q <= ADD;
        end
        ADD: begin
          x_q <= x_q >> CHUNK;
          y_q <= y_q >> CHUNK;
          c_q <= add_d[CHUNK];
          r_q <= r_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == LAST) begin
            sum_q <= r_d;
            co_q <= add_d[CHUNK];
            ov_q <= msb_c_d ^ add_d[CHUNK];
            out_valid_q <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum = sum_q;
  assign bus.carryout = co_q;
  assign bus.overflow = ov_q;
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: scoreboard bench for seq_chunk_adder (WIDTH=8, CHUNK=2)
module tb_seq_chunk_adder;
  typedef logic [9:0] res_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  res_t q[$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  seq_chunk_adder_if #(.WIDTH(8)) bus ();
  seq_chunk_adder #(.WIDTH(8), .CHUNK(2)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  function automatic res_t model(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    logic [7:0] bb;
    logic       c;
    logic [8:0] t;
    bb = sb ? ~b : b;
    c = sb ? 1'b1 : ci;
    t = {1'b0, a} + {1'b0, bb} + {8'd0, c};
    return {t[7:0], t[8], (a[7] == bb[7]) && (t[7] != a[7])};
  endfunction
  function automatic res_t obs();
    return {bus.sum, bus.carryout, bus.overflow};
  endfunction
  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.carryin = 1'b0;
    bus.x = 8'h00;
    bus.y = 8'h00;
    bus.out_ready = 1'b0;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.sub = 1'b0;
`endif
  endtask
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic sb);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n == 50) begin
      tests++; fails++;
      $display("FAIL send_timeout in_ready=%b required=1", bus.in_ready);
    end
    bus.x = a;
    bus.y = b;
    bus.carryin = ci;
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    bus.sub = sb;
`endif
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    q.push_back(model(a, b, ci, sb));
  endtask
  task automatic wait_out(output int lat);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask
  task automatic release_out();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask
  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    tests++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    tests++;
    if (obs() !== 10'h000) begin fails++; $display("FAIL reset_result got=%h exp=000", obs()); end
    reset = 1'b0;
  endtask
  task automatic test_carry_wrap();
    int lat;
    res_t e;
    send(8'hFF, 8'h01, 1'b0, 1'b0);
    wait_out(lat);
    e = q.pop_front();
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    tests++;
    if (obs() !== {8'h00, 1'b1, 1'b0}) begin fails++; $display("FAIL wrap_result got=%h exp=%h", obs(), {8'h00, 1'b1, 1'b0}); end
    tests++;
    if (obs() !== e) begin fails++; $display("FAIL wrap_model got=%h exp=%h", obs(), e); end
    release_out();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL wrap_release got=%b exp=01", {bus.out_valid, bus.in_ready}); end
  endtask
  task automatic test_overflow();
    int lat;
    res_t e;
    send(8'h7F, 8'h01, 1'b0, 1'b0);
    wait_out(lat);
    e = q.pop_front();
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL ovf_latency got=%0d exp=4", lat); end
    tests++;
    if (obs() !== {8'h80, 1'b0, 1'b1} || obs() !== e) begin fails++; $display("FAIL ovf_result got=%h exp=%h", obs(), {8'h80, 1'b0, 1'b1}); end
    release_out();
  endtask
  task automatic test_backpressure();
    int lat;
    res_t e;
    send(8'h12, 8'h34, 1'b1, 1'b0);
    wait_out(lat);
    e = q.pop_front();
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL bp_latency got=%0d exp=4", lat); end
    bus.x = 8'hAA;
    bus.y = 8'h55;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests++;
      if ({bus.out_valid, bus.in_ready, obs()} !== {2'b10, 8'h47, 2'b00} || obs() !== e)
        begin fails++; $display("FAIL bp_hold cyc=%0d got=%b_%h exp=10_%h", i, {bus.out_valid, bus.in_ready}, obs(), {8'h47, 2'b00}); end
    end
    bus.in_valid = 1'b0;
    release_out();
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL bp_release got=%b exp=01", {bus.out_valid, bus.in_ready}); end
    tests++;
    if (obs() !== {8'h47, 2'b00}) begin fails++; $display("FAIL bp_after_hold got=%h exp=%h", obs(), {8'h47, 2'b00}); end
    repeat (3) begin
      @(posedge clk); #1;
      tests++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_no_ghost got=%b exp=0", bus.out_valid); end
    end
  endtask
  task automatic test_reset_mid();
    int lat;
    logic seen = 1'b0;
    send(8'h33, 8'h44, 1'b0, 1'b0);
    void'(q.pop_front());
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests++;
    if ({bus.in_ready, bus.out_valid, obs()} !== 12'h800) begin fails++; $display("FAIL midrst_state got=%h exp=800", {bus.in_ready, bus.out_valid, obs()}); end
    repeat (6) begin
      @(posedge clk); #1;
      seen |= bus.out_valid;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL midrst_no_pulse got=%b exp=0", seen); end
    send(8'h0A, 8'h05, 1'b0, 1'b0);
    wait_out(lat);
    tests++;
    if (lat !== 4 || obs() !== {8'h0F, 2'b00} || obs() !== q.pop_front())
      begin fails++; $display("FAIL midrst_next lat=%0d got=%h exp=%h", lat, obs(), {8'h0F, 2'b00}); end
    release_out();
  endtask
  task automatic test_early_ready();
    int lat;
    send(8'hC8, 8'h64, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    wait_out(lat);
    tests++;
    if (lat !== 4 || obs() !== {8'h2D, 1'b1, 1'b0} || obs() !== q.pop_front())
      begin fails++; $display("FAIL early_ready lat=%0d got=%h exp=%h", lat, obs(), {8'h2D, 1'b1, 1'b0}); end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    tests++;
    if ({bus.out_valid, bus.in_ready} !== 2'b01) begin fails++; $display("FAIL early_drop got=%b exp=01", {bus.out_valid, bus.in_ready}); end
  endtask
  task automatic test_back_to_back();
    int lat;
    res_t e;
    logic sb;
    for (int i = 0; i < 20; i++) begin
`ifdef SEQ_CHUNK_ADDER_SUB_EN
      sb = 1'($urandom_range(0, 1));
`else
      sb = 1'b0;
`endif
      send(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), sb);
      wait_out(lat);
      e = q.pop_front();
      tests++;
      if (lat !== 4 || obs() !== e) begin fails++; $display("FAIL b2b op=%0d lat=%0d got=%h exp=%h", i, lat, obs(), e); end
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      release_out();
    end
    tests++;
    if (q.size() !== 0) begin fails++; $display("FAIL b2b_queue got=%0d exp=0", q.size()); end
  endtask
`ifdef SEQ_CHUNK_ADDER_SUB_EN
  task automatic test_sub();
    int lat;
    send(8'h05, 8'h07, 1'b0, 1'b1);
    wait_out(lat);
    tests++;
    if (lat !== 4 || obs() !== {8'hFE, 1'b0, 1'b0} || obs() !== q.pop_front())
      begin fails++; $display("FAIL sub_borrow lat=%0d got=%h exp=%h", lat, obs(), {8'hFE, 2'b00}); end
    release_out();
    send(8'h80, 8'h01, 1'b0, 1'b1);
    wait_out(lat);
    tests++;
    if (lat !== 4 || obs() !== {8'h7F, 1'b1, 1'b1} || obs() !== q.pop_front())
      begin fails++; $display("FAIL sub_ovf lat=%0d got=%h exp=%h", lat, obs(), {8'h7F, 2'b11}); end
    release_out();
  endtask
`endif
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_early_ready();
`ifdef SEQ_CHUNK_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised, multi-cycle successor to the team's combinational ripple adders.
- Adds two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, using a single CHUNK-bit full-adder slice and a registered carry between chunks.
- Operands enter and results leave over valid/ready handshakes, so the block sits between register-stage producers and consumers in the datapath labs.
- Trades latency for area on wide operands.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- CHUNK, 2, bits added per cycle; must be >= 1 with WIDTH % CHUNK == 0. NCHUNK = WIDTH/CHUNK.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept operands
- carryin  input  1  carry into bit 0
- x  input  WIDTH  operand A
- y  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered result
- carryout  output  1  carry out of bit WIDTH-1
- overflow  output  1  two's-complement overflow (carry into MSB XOR carryout)

Behaviour:
- Clock and reset: one clock clk; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset value of every output (from the first edge with reset=1):
  - state = IDLE
  - in_ready = 1
  - out_valid = 0
  - sum = 0, carryout = 0, overflow = 0
  - internal shift registers, carry register and chunk counter = 0
- FSM states: IDLE, ADD, DONE. Outputs are decoded from state and registers only; there is no combinational path from any input to any output.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: capture x, y, carryin into operand shift registers and the carry register; clear the chunk counter; go to ADD.
- ADD:
  - in_ready = 0.
  - Each cycle: {c, s} = x_sh[CHUNK-1:0] + y_sh[CHUNK-1:0] + carry.
  - Shift s into the result register from the MSB end; shift x_sh and y_sh right by CHUNK; carry <= c; counter++.
  - On the final chunk (counter == NCHUNK-1), also record the carry into bit WIDTH-1.
  - After NCHUNK ADD cycles: load sum, carryout and overflow; set out_valid = 1; go to DONE.
- Latency: out_valid rises exactly NCHUNK cycles after the accepting edge. With CHUNK == WIDTH, ADD lasts 1 cycle.
- DONE:
  - out_valid = 1; sum, carryout and overflow held stable.
  - in_ready = 0; in_valid is ignored.
  - On out_ready: out_valid <= 0, go to IDLE.
- Throughput: one operation per NCHUNK+2 cycles at minimum.
- Output holding: sum, carryout and overflow keep the last completed result after the out handshake, until the next DONE entry or reset.
- Arithmetic: modulo 2^WIDTH; carryout is the true unsigned carry.
- Boundary conditions:
  - out_ready asserted before DONE has no effect.
  - out_valid stays asserted indefinitely while out_ready = 0.
  - reset in any state, including mid-ADD, abandons the operation; no out_valid pulse is produced for it.
  - reset has priority over all handshakes in the same cycle.

Optional Feature:
- Macro: SEQ_CHUNK_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), captured with the operands.
  - When sub = 1: the block computes x + ~y + 1. carryin is ignored and the carry register is loaded with 1. carryout = 1 means no borrow. overflow is signed-subtraction overflow.
  - When sub = 0: behaviour is identical to the undefined case.
- Undefined: no sub port; addition only.

Test Plan (WIDTH=8, CHUNK=2):
- Reset: assert reset for 2 cycles -> in_ready=1, out_valid=0, sum=0x00, carryout=0, overflow=0.
- Carry wrap: x=0xFF, y=0x01, carryin=0, accepted at edge T -> out_valid high from edge T+4; sum=0x00, carryout=1, overflow=0.
- Signed overflow: x=0x7F, y=0x01, carryin=0 -> sum=0x80, carryout=0, overflow=1.
- Backpressure: x=0x12, y=0x34, carryin=1 with out_ready held low 5 cycles after out_valid -> sum=0x47 held stable, in_ready=0, a concurrent in_valid is not accepted; out_ready=1 -> out_valid falls next edge and in_ready=1.
- Reset mid-operation: reset on the 2nd ADD cycle -> next cycle state IDLE, out_valid never rises for that operation; a following op 0x0A+0x05+0 -> sum=0x0F after 4 cycles.
- SEQ_CHUNK_ADDER_SUB_EN defined: sub=1, x=0x05, y=0x07 -> sum=0xFE, carryout=0, overflow=0; sub=1, x=0x80, y=0x01 -> sum=0x7F, carryout=1, overflow=1.
